// File: rtl/hazard_ctrl_pkg.sv
// Shared MIPS decode constants: opcodes, functs, Tuse/Tnew encodings and the
// per-instruction hazard descriptor produced by instr_class.
package mips_defs;

  localparam logic [5:0] SPECIAL = 6'h00;
  localparam logic [5:0] JAL     = 6'h03;
  localparam logic [5:0] BEQ     = 6'h04;
  localparam logic [5:0] BNE     = 6'h05;
  localparam logic [5:0] ORI     = 6'h0D;
  localparam logic [5:0] LUI     = 6'h0F;
  localparam logic [5:0] LW      = 6'h23;
  localparam logic [5:0] SW      = 6'h2B;

  localparam logic [5:0] JR      = 6'h08;
  localparam logic [5:0] JALR    = 6'h09;
  localparam logic [5:0] MFHI    = 6'h10;
  localparam logic [5:0] MTHI    = 6'h11;
  localparam logic [5:0] MFLO    = 6'h12;
  localparam logic [5:0] MTLO    = 6'h13;
  localparam logic [5:0] MULT    = 6'h18;
  localparam logic [5:0] MULTU   = 6'h19;
  localparam logic [5:0] DIV     = 6'h1A;
  localparam logic [5:0] DIVU    = 6'h1B;
  localparam logic [5:0] ADD     = 6'h20;
  localparam logic [5:0] ADDU    = 6'h21;
  localparam logic [5:0] SUB     = 6'h22;
  localparam logic [5:0] SUBU    = 6'h23;

  // TNONE marks an unread source: it is never below any Tnew (max 2).
  localparam logic [1:0] T0    = 2'd0;
  localparam logic [1:0] T1    = 2'd1;
  localparam logic [1:0] T2    = 2'd2;
  localparam logic [1:0] TNONE = 2'd3;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dest;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [1:0] tnew_e;
    logic       is_md;
    logic       is_md_start;
    logic       is_div;
  } instr_info_t;

endpackage

// File: rtl/hazard_ctrl_instr_class.sv
// Combinational IR decode into source/dest registers, Tuse per source,
// Tnew as seen from E, and HI/LO unit classification.
module instr_class
  import mips_defs::*;
(
  input  logic [31:0] ir,
  output instr_info_t info
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_shamt;

  assign op           = ir[31:26];
  assign fn           = ir[5:0];
  assign unused_shamt = ^ir[10:6];

  always_comb begin
    info             = '0;
    info.rs          = ir[25:21];
    info.rt          = ir[20:16];
    info.tuse_rs     = TNONE;
    info.tuse_rt     = TNONE;
    info.tnew_e      = T0;
    case (op)
      SPECIAL: begin
        case (fn)
          ADD, ADDU, SUB, SUBU: begin
            info.dest    = ir[15:11];
            info.tuse_rs = T1;
            info.tuse_rt = T1;
            info.tnew_e  = T1;
          end
          JR: info.tuse_rs = T0;
          JALR: begin
            info.dest    = ir[15:11];
            info.tuse_rs = T0;
          end
          MFHI, MFLO: begin
            info.dest   = ir[15:11];
            info.tnew_e = T1;
            info.is_md  = 1'b1;
          end
          MTHI, MTLO: begin
            info.tuse_rs = T1;
            info.is_md   = 1'b1;
          end
          MULT, MULTU, DIV, DIVU: begin
            info.tuse_rs     = T1;
            info.tuse_rt     = T1;
            info.is_md       = 1'b1;
            info.is_md_start = 1'b1;
            info.is_div      = (fn == DIV) || (fn == DIVU);
          end
          default: ;
        endcase
      end
      LW: begin
        info.dest    = ir[20:16];
        info.tuse_rs = T1;
        info.tnew_e  = T2;
      end
      SW: begin
        info.tuse_rs = T1;
        info.tuse_rt = T2;
      end
      BEQ, BNE: begin
        info.tuse_rs = T0;
        info.tuse_rt = T0;
      end
      JAL: info.dest = REG_RA;
      ORI: begin
        info.dest    = ir[20:16];
        info.tuse_rs = T1;
        info.tnew_e  = T1;
      end
      LUI: begin
        info.dest   = ir[20:16];
        info.tnew_e = T1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush control for the 5-stage core: Tuse/Tnew interlock of D
// against E and M producers, plus the busy counter serialising the HI/LO unit.
module hazard_ctrl
  import mips_defs::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] D_IR,
  input  logic [31:0] E_IR,
  input  logic [31:0] M_IR,
  output logic        PC_We,
  output logic        D_We,
  output logic        E_Flush,
  output logic        M_We,
  output logic        W_We,
  output logic        md_start,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);

  instr_info_t      d_info, e_info, m_info;
  logic [CNT_W-1:0] mdu_cnt;
  logic [1:0]       tnew_m;
  logic             data_stall, md_stall, stall;
  logic             unused_fields;

  function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] dest, input logic [1:0] tnew);
    return (dest != 5'd0) && (src == dest) && (tuse < tnew);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  instr_class u_d_class (.ir(D_IR), .info(d_info));
  instr_class u_e_class (.ir(E_IR), .info(e_info));
  instr_class u_m_class (.ir(M_IR), .info(m_info));

  assign unused_fields = ^{d_info.dest, d_info.tnew_e, d_info.is_md_start, d_info.is_div,
                           e_info.rs, e_info.rt, e_info.tuse_rs, e_info.tuse_rt, e_info.is_md,
                           m_info.rs, m_info.rt, m_info.tuse_rs, m_info.tuse_rt,
                           m_info.is_md, m_info.is_md_start, m_info.is_div};

  // One stage further down, every producer is one cycle closer to its result.
  assign tnew_m = (m_info.tnew_e == T0) ? T0 : m_info.tnew_e - 2'd1;

  assign data_stall =
      src_hazard(d_info.rs, d_info.tuse_rs, e_info.dest, e_info.tnew_e) ||
      src_hazard(d_info.rt, d_info.tuse_rt, e_info.dest, e_info.tnew_e) ||
      src_hazard(d_info.rs, d_info.tuse_rs, m_info.dest, tnew_m) ||
      src_hazard(d_info.rt, d_info.tuse_rt, m_info.dest, tnew_m);

  assign md_busy  = (mdu_cnt != '0);
  assign md_start = !Rst && !md_busy && e_info.is_md_start;
  assign md_stall = (md_busy || md_start) && d_info.is_md;
  assign stall    = data_stall || md_stall;

  always_comb begin
    PC_We   = 1'b1;
    D_We    = 1'b1;
    E_Flush = 1'b0;
    M_We    = 1'b1;
    W_We    = 1'b1;
    if (Rst) begin
      E_Flush = 1'b1;
    end else if (stall) begin
      PC_We   = 1'b0;
      D_We    = 1'b0;
      E_Flush = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      mdu_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (md_start)
        mdu_cnt <= e_info.is_div ? DIV_LD : MULT_LD;
      else if (md_busy)
        mdu_cnt <= mdu_cnt - CNT_W'(1);
      if (stall)
        stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: the driver queues hand-computed
// expectations per cycle, the monitor pops and compares them at the falling edge.
module tb_hazard_ctrl;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] LW1    = 32'h8C01_0000;
  localparam logic [31:0] LW0    = 32'h8C00_0000;
  localparam logic [31:0] LW31   = 32'h8C1F_0000;
  localparam logic [31:0] ADD211 = 32'h0021_1020;
  localparam logic [31:0] ADD123 = 32'h0043_0820;
  localparam logic [31:0] ADD200 = 32'h0000_1020;
  localparam logic [31:0] BEQ10  = 32'h1020_0003;
  localparam logic [31:0] SW_RT1 = 32'hAC01_0000;
  localparam logic [31:0] SW_RS1 = 32'hAC20_0000;
  localparam logic [31:0] JAL0   = 32'h0C00_0000;
  localparam logic [31:0] JR31   = 32'h03E0_0008;
  localparam logic [31:0] MULT23 = 32'h0043_0018;
  localparam logic [31:0] DIV23  = 32'h0043_001A;
  localparam logic [31:0] MFLO4  = 32'h0000_2012;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] D_IR = '0, E_IR = '0, M_IR = '0;
  logic        PC_We, D_We, E_Flush, M_We, W_We, md_start, md_busy;
  logic [31:0] stall_cnt;

  typedef struct {
    string       name;
    logic [38:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  hazard_ctrl dut (
    .Clk(Clk), .Rst(Rst), .D_IR(D_IR), .E_IR(E_IR), .M_IR(M_IR),
    .PC_We(PC_We), .D_We(D_We), .E_Flush(E_Flush), .M_We(M_We), .W_We(W_We),
    .md_start(md_start), .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 Clk = ~Clk;

  // Apply one cycle of inputs just after the rising edge and queue what the
  // outputs must read during that cycle.
  task automatic drive(input logic rst, input logic [31:0] d, input logic [31:0] e,
                       input logic [31:0] m, input logic stl, input logic st,
                       input logic bz, input logic [31:0] sc, input string nm,
                       input bit preload = 1'b0);
    exp_t       x;
    logic [2:0] ctl;
    @(posedge Clk);
    #1;
    if (preload) force dut.stall_cnt = 32'hFFFF_FFFE;
    Rst  = rst;
    D_IR = d;
    E_IR = e;
    M_IR = m;
    if (rst)      ctl = 3'b111;
    else if (stl) ctl = 3'b001;
    else          ctl = 3'b110;
    x.name = nm;
    x.v    = {ctl, 1'b1, 1'b1, st, bz, sc};
    exp_q.push_back(x);
    if (preload) begin
      #2;
      release dut.stall_cnt;
    end
  endtask

  initial begin : monitor
    exp_t        x;
    logic [38:0] act;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        x   = exp_q.pop_front();
        act = {PC_We, D_We, E_Flush, M_We, W_We, md_start, md_busy, stall_cnt};
        checks++;
        if (act !== x.v) begin
          failures++;
          $display("FAIL %s: got pc/d/fl/m/w/st/bz=%b cnt=%h, want %b cnt=%h",
                   x.name, act[38:32], act[31:0], x.v[38:32], x.v[31:0]);
        end
      end
    end
  end

  initial begin : stimulus
    //    rst  D       E       M       stall st bz cnt
    drive(1, NOP,    NOP,    NOP,    0, 0, 0, 0, "reset0");
    drive(1, NOP,    NOP,    NOP,    0, 0, 0, 0, "reset1");
    drive(0, NOP,    NOP,    NOP,    0, 0, 0, 0, "idle");
    drive(0, ADD211, LW1,    NOP,    1, 0, 0, 0, "load_use_E");
    drive(0, ADD211, NOP,    LW1,    0, 0, 0, 1, "load_use_M");
    drive(0, BEQ10,  ADD123, NOP,    1, 0, 0, 1, "branch_alu_E");
    drive(0, BEQ10,  NOP,    ADD123, 0, 0, 0, 2, "branch_alu_M");
    drive(0, ADD211, ADD123, NOP,    0, 0, 0, 2, "alu_alu_E");
    drive(0, SW_RT1, LW1,    NOP,    0, 0, 0, 2, "store_rt_load");
    drive(0, SW_RS1, LW1,    NOP,    1, 0, 0, 2, "store_rs_load");
    drive(0, ADD200, LW0,    NOP,    0, 0, 0, 3, "zero_dest");
    drive(0, JR31,   JAL0,   NOP,    0, 0, 0, 3, "jr_after_jal");
    drive(0, JR31,   NOP,    LW31,   1, 0, 0, 3, "jr_load_M");
    drive(0, NOP,    NOP,    NOP,    0, 0, 0, 4, "idle2");

    drive(0, MFLO4,  MULT23, NOP,    1, 1, 0, 4, "mult_start");
    for (int i = 0; i < 5; i++)
      drive(0, MFLO4, NOP, NOP, 1, 0, 1, 32'(5 + i), $sformatf("mflo_wait%0d", i));
    drive(0, MFLO4,  NOP,    NOP,    0, 0, 0, 10, "mflo_release");

    drive(0, NOP,    MULT23, NOP,    0, 1, 0, 10, "mult_start2");
    for (int i = 0; i < 5; i++)
      drive(0, NOP, MULT23, NOP, 0, 0, 1, 10, $sformatf("mult_hold%0d", i));
    drive(0, NOP,    MULT23, NOP,    0, 1, 0, 10, "mult_back2back");
    for (int i = 0; i < 5; i++)
      drive(0, NOP, NOP, NOP, 0, 0, 1, 10, $sformatf("mult_drain%0d", i));
    drive(0, NOP,    NOP,    NOP,    0, 0, 0, 10, "mult_idle");

    drive(0, NOP,    DIV23,  NOP,    0, 1, 0, 10, "div_start");
    for (int i = 0; i < 3; i++)
      drive(0, NOP, NOP, NOP, 0, 0, 1, 10, $sformatf("div_busy%0d", i));
    drive(1, NOP,    NOP,    NOP,    0, 0, 1, 10, "div_reset_mid");
    drive(0, NOP,    NOP,    NOP,    0, 0, 0, 0,  "div_after_reset");

    drive(0, ADD211, LW1,    NOP,    1, 0, 0, 32'hFFFF_FFFE, "sat_preload", 1'b1);
    drive(0, ADD211, LW1,    NOP,    1, 0, 0, 32'hFFFF_FFFF, "sat_reach");
    drive(0, ADD211, LW1,    NOP,    1, 0, 0, 32'hFFFF_FFFF, "sat_hold");
    drive(0, NOP,    NOP,    NOP,    0, 0, 0, 32'hFFFF_FFFF, "sat_idle");

    for (int i = 0; i < 4 && exp_q.size() > 0; i++)
      @(negedge Clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline control for the 5-stage MIPS core. It drives the write-enable and flush inputs of the F/D, D/E, E/M and M/W pipeline registers, which are the consumers of these controls. It makes stall decisions from Tuse/Tnew comparison of the instruction in D against the producers in E and M. It owns the multiply/divide busy counter, which serialises HI/LO instructions behind a multi-cycle MDU.

Parameters:
MULT_CYC, 5, busy cycles after mult/multu issue from E
DIV_CYC, 10, busy cycles after div/divu issue from E
CNT_W, 4, width of busy counter; must hold max(MULT_CYC, DIV_CYC)

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  reset, synchronous, active-high
D_IR  input  32  instruction in D stage
E_IR  input  32  instruction in E stage (D/E register output)
M_IR  input  32  instruction in M stage (E/M register output)
PC_We  output  1  PC write enable
D_We  output  1  F/D register write enable
E_Flush  output  1  synchronous clear of D/E register (bubble insert)
M_We  output  1  E/M register write enable
W_We  output  1  M/W register write enable
md_start  output  1  one-cycle MDU start pulse
md_busy  output  1  MDU occupied
stall_cnt  output  32  total stall cycles since reset, saturating

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous, active-high, on port Rst. On the Rst edge: busy counter = 0 and stall_cnt = 0. md_start and md_busy are therefore 0 in the cycle after reset.
- The stall and enable outputs are combinational from IRs and state. While Rst = 1 they are forced: PC_We = D_We = M_We = W_We = 1, E_Flush = 1, md_start = 0.
- Tnew (cycles until result available), by stage:
  - E stage: load = 2; ALU R/I-type, lui, mfhi, mflo = 1; jal/jalr link = 0.
  - M stage: load = 1; all others = 0.
  - Non-writers, and writers whose dest is $0, are never producers.
- Tuse, for the D instruction:
  - beq/bne/jr/jalr rs = 0.
  - ALU rs/rt = 1; load rs = 1; store rs = 1, store rt = 2; mthi/mtlo rs = 1; mult/div rs and rt = 1.
  - Unused source fields are ignored.
- Dest register: rd for R-type, rt for I-type, 31 for jal.
- Data stall: a D source reg equals a producer's nonzero dest and Tuse < Tnew. Check the E producer and the M producer independently and OR the results.
- MD stall: (md_busy or md_start) and the D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- stall = data stall or MD stall.
- On stall: PC_We = 0, D_We = 0, E_Flush = 1.
- M_We and W_We stay 1 on a stall; the back end always drains.
- With no stall: PC_We = D_We = 1, E_Flush = 0.
- md_start = 1 when E_IR is mult/multu/div/divu and the counter = 0. It lasts exactly one cycle, because the next cycle the counter is nonzero or E_IR has changed.
- Counter update:
  - On the edge with md_start: counter <= MULT_CYC or DIV_CYC.
  - Else if counter != 0: decrement.
  - md_busy = (counter != 0).
- An MD instruction cannot enter E while busy, because D is stalled; no overlap handling is required.
- Counter reaching 0 while the next mult sits in E: md_start asserts in that cycle, so there is zero idle gap.
- Reset mid-count: the counter clears on the edge and md_busy drops the next cycle.
- stall_cnt increments on each edge where stall = 1. It holds at 0xFFFFFFFF.

Decomposition:
- Shared package (mips_defs): opcode/funct constants (LW, SW, BEQ, BNE, JAL, JR, JALR, SPECIAL, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO, ADDU, SUBU, ORI, LUI), Tuse/Tnew encodings (2-bit), and the register number 31.
- One sub-module, instr_class: combinational IR decode into rs/rt/dest, Tuse_rs/Tuse_rt, Tnew_E, and the is_md/is_md_start flags. Instantiate it three times (D, E, M).

Test Plan:
- E = lw $1,0($0) (0x8C010000), D = add $2,$1,$1 (0x00211020) -> stall = 1: PC_We = 0, D_We = 0, E_Flush = 1, stall_cnt 0->1. Next cycle, with lw in M and a bubble in E -> no stall.
- E = add $1,$2,$3 (0x00430820), D = beq $1,$0 (0x10200003) -> stall one cycle. Then add in M (Tnew 0) -> no stall.
- E = lw $0,0($0) (0x8C000000), D = add $2,$0,$0 (0x00001020) -> no stall; a $0 dest is ignored.
- E = mult $2,$3 (0x00430018) -> md_start = 1 for 1 cycle, md_busy = 1 for 5 cycles. D = mflo $4 (0x00002012) stalls through those cycles and releases the cycle md_busy falls.
- div in E (DIV_CYC = 10), Rst asserted on the 4th busy cycle -> counter = 0 and md_busy = 0 the next cycle; stall_cnt = 0.
- Force 2^32 stall cycles (preload via hierarchical force of stall_cnt to 0xFFFFFFFE) -> stall_cnt saturates at 0xFFFFFFFF.
